// File: rtl/ex_alu_stage.sv
// Single-cycle integer ALU execute stage. A registered result slot uses a
// valid/ready handshake on each side and counts completed output handshakes.
module ex_alu_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_zero,
  output logic [31:0]      op_count
);

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpAnd   = 3'b010,
    OpOr    = 3'b011,
    OpXor   = 3'b100,
    OpSlt   = 3'b101,
    OpSltu  = 3'b110,
    OpPassB = 3'b111
  } alu_op_e;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rd_q, rd_d;
  logic             zero_q, zero_d;
  logic [31:0]      op_count_q, op_count_d;

  logic             in_hs;
  logic             out_hs;
  logic [WIDTH-1:0] alu_res;

  assign in_ready = !valid_q || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = valid_q && out_ready;

  // Combinational ALU; add/sub wrap naturally at WIDTH bits.
  always_comb begin
    alu_res = '0;
    unique case (alu_op_e'(in_op))
      OpAdd:   alu_res = in_a + in_b;
      OpSub:   alu_res = in_a - in_b;
      OpAnd:   alu_res = in_a & in_b;
      OpOr:    alu_res = in_a | in_b;
      OpXor:   alu_res = in_a ^ in_b;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OpPassB: alu_res = in_b;
      default: alu_res = '0;
    endcase
  end

  // Next-state for the result slot and handshake counter.
  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    rd_d       = rd_q;
    zero_d     = zero_q;
    op_count_d = op_count_q + {31'd0, out_hs};

    if (flush) begin
      // Flush drops both the held result and whatever is presented now.
      valid_d = 1'b0;
    end else if (in_hs) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      rd_d     = in_rd;
      zero_d   = (alu_res == '0);
    end else if (out_hs) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      zero_q     <= 1'b1;
      op_count_q <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      zero_q     <= zero_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_zero   = zero_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: hand-computed vectors, checked 1 ns after
// each rising edge.
module tb_ex_alu_stage;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic [4:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_rd;
  logic         out_zero;
  logic [31:0]  op_count;

  int checks = 0;
  int errors = 0;

  ex_alu_stage #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_zero   (out_zero),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] rd);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 5'd0);

    // Reset values
    step();
    step();
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_result", out_result, 0);
    chk("rst_rd", W'(out_rd), 0);
    chk("rst_zero", W'(out_zero), 1);
    chk("rst_count", W'(op_count), 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", W'(in_ready), 1);

    // ADD wrap to zero
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5);
    step();
    chk("add_valid", W'(out_valid), 1);
    chk("add_result", out_result, 64'd0);
    chk("add_zero", W'(out_zero), 1);
    chk("add_rd", W'(out_rd), 5);
    chk("add_count_pre", W'(op_count), 0);
    drive(1'b0, 3'b000, '0, '0, 5'd0);
    step();
    chk("add_count", W'(op_count), 1);
    chk("drain_valid", W'(out_valid), 0);

    // Back-to-back logic ops, no bubble
    drive(1'b1, 3'b010, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd1);
    step();
    chk("and_result", out_result, 64'hF000_F000_F000_F000);
    chk("and_valid", W'(out_valid), 1);
    drive(1'b1, 3'b011, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd2);
    step();
    chk("or_result", out_result, 64'hFFF0_FFF0_FFF0_FFF0);
    chk("or_valid", W'(out_valid), 1);
    chk("or_rd", W'(out_rd), 2);
    drive(1'b1, 3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd3);
    step();
    chk("xor_result", out_result, 64'h0FF0_0FF0_0FF0_0FF0);
    chk("xor_valid", W'(out_valid), 1);

    // Compare ops, SUB underflow, PASSB
    drive(1'b1, 3'b101, 64'h8000_0000_0000_0000, 64'd1, 5'd4);
    step();
    chk("slt_result", out_result, 64'd1);
    chk("slt_zero", W'(out_zero), 0);
    drive(1'b1, 3'b110, 64'h8000_0000_0000_0000, 64'd1, 5'd4);
    step();
    chk("sltu_result", out_result, 64'd0);
    chk("sltu_zero", W'(out_zero), 1);
    drive(1'b1, 3'b001, 64'd0, 64'd1, 5'd6);
    step();
    chk("sub_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_zero", W'(out_zero), 0);
    drive(1'b1, 3'b111, 64'hDEAD, 64'h1234_5678_9ABC_DEF0, 5'd7);
    step();
    chk("passb_result", out_result, 64'h1234_5678_9ABC_DEF0);
    drive(1'b0, 3'b000, '0, '0, 5'd0);
    step();
    chk("burst_count", W'(op_count), 8);

    // Backpressure: held result stays stable, new input ignored
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 64'd3, 64'd4, 5'd9);
    step();
    chk("stall_load", out_result, 64'd7);
    drive(1'b1, 3'b011, 64'hAA, 64'h55, 5'd12);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", W'(in_ready), 0);
      step();
      chk("stall_valid", W'(out_valid), 1);
      chk("stall_result", out_result, 64'd7);
      chk("stall_rd", W'(out_rd), 9);
      chk("stall_count", W'(op_count), 8);
    end
    drive(1'b0, 3'b000, '0, '0, 5'd0);
    out_ready = 1'b1;
    step();
    chk("release_valid", W'(out_valid), 0);
    chk("release_count", W'(op_count), 9);

    // Flush while held and stalled
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 64'd10, 64'd5, 5'd3);
    step();
    chk("flush_load", out_result, 64'd15);
    flush = 1'b1;
    drive(1'b1, 3'b000, 64'd100, 64'd1, 5'd7);
    step();
    chk("flush_valid", W'(out_valid), 0);
    chk("flush_count", W'(op_count), 9);
    flush = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 5'd0);
    step();
    chk("flush_no_deliver", W'(out_valid), 0);

    // Flush drops an input that would otherwise handshake
    out_ready = 1'b1;
    flush     = 1'b1;
    drive(1'b1, 3'b000, 64'd1, 64'd1, 5'd8);
    step();
    chk("flush_in_drop", W'(out_valid), 0);
    flush = 1'b0;

    // Flush coincident with an output handshake still counts it
    step();
    chk("reload_valid", W'(out_valid), 1);
    chk("reload_result", out_result, 64'd2);
    chk("reload_count", W'(op_count), 9);
    flush = 1'b1;
    step();
    chk("flush_hs_valid", W'(out_valid), 0);
    chk("flush_hs_count", W'(op_count), 10);
    flush = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 5'd0);

    // Counter wrap from a forced preload
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_count_q;
    #1;
    chk("preload_count", W'(op_count), 64'hFFFF_FFFF);
    drive(1'b1, 3'b000, 64'd1, 64'd2, 5'd1);
    step();
    drive(1'b0, 3'b000, '0, '0, 5'd0);
    step();
    chk("wrap_count", W'(op_count), 0);

    // Reset mid-stream overrides flush and handshakes
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 64'd0, 64'h55, 5'd11);
    step();
    chk("pre_rst_valid", W'(out_valid), 1);
    rst_n     = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_rd", W'(out_rd), 0);
    chk("mid_rst_zero", W'(out_zero), 1);
    chk("mid_rst_count", W'(op_count), 0);
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 5'd0);
    #1;
    chk("post_rst_ready", W'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
